// File: rtl/r_channel_buf.sv
// OBI R-channel response buffer: DEPTH-entry show-ahead FIFO between the cache controller
// and the OBI master, with rvalid/rready backpressure and a dropped-response pulse.
module r_channel_buf #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Controller side
  input  logic                  rvalid_in,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  input  logic                  err_in,
  input  logic [ID_WIDTH-1:0]   rid_in,
  output logic                  rready_in,
  // OBI master side
  output logic                  obi_rvalid,
  input  logic                  obi_rready,
  output logic [DATA_WIDTH-1:0] obi_rdata,
  output logic                  obi_err,
  output logic [ID_WIDTH-1:0]   obi_rid,
  // Status
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned EntryWidth = DATA_WIDTH + 1 + ID_WIDTH;

  logic [EntryWidth-1:0] mem_q [DEPTH];
  logic [EntryWidth-1:0] head;

  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop;

  // Full/empty come from the registered count only, so no input reaches these paths.
  assign rready_in  = (count_q != CNT_WIDTH'(DEPTH));
  assign obi_rvalid = (count_q != '0);

  assign push = rvalid_in & rready_in;
  assign pop  = obi_rvalid & obi_rready;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = rvalid_in & ~rready_in;
    if (push) begin
      wptr_d = wptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrWidth'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {rdata_in, err_in, rid_in};
    end
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    obi_rdata = '0;
    obi_err   = 1'b0;
    obi_rid   = '0;
    if (obi_rvalid) begin
      obi_rdata = head[EntryWidth-1 -: DATA_WIDTH];
      obi_err   = head[ID_WIDTH];
      obi_rid   = head[ID_WIDTH-1:0];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
